// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with an iterative multiply/divide unit and HI/LO.
// Single-cycle logic ops finish on the accept edge. MULT/MULTU/DIV/DIVU run
// WIDTH CALC iterations and then one FIX cycle before HI/LO are written.
//
// Handshake: start is sampled only while the FSM is IDLE (busy=0). An
// accepted request produces exactly one done pulse, one cycle wide. This
// holds unless reset arrives first. A start seen while busy=1 is dropped.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Result/status registers
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Multiply/divide working registers
  logic [WIDTH-1:0] r_m;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_acc_hi;  // partial product high half / partial remainder
  logic [WIDTH-1:0] r_acc_lo;  // multiplier being consumed / quotient
  logic [WIDTH-1:0] r_dvd;     // raw dividend, reported in HI on divide by zero
  logic             r_is_div;
  logic             r_neg_res; // product / quotient needs negation
  logic             r_neg_a;   // remainder follows the dividend sign
  logic             r_b_zero;
  logic [CNT_W-1:0] r_cnt;

  // Decode and single-cycle datapath
  logic             w_is_md;
  logic             w_signed_md;
  logic             w_op_div;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;

  // Iteration datapath
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_md     = (alu_control[3:2] == 2'b10);
  assign w_signed_md = ~alu_control[0];
  assign w_op_div    = alu_control[1];
  assign w_abs_a     = (w_signed_md && regA[WIDTH-1]) ? -regA : regA;
  assign w_abs_b     = (w_signed_md && regB[WIDTH-1]) ? -regB : regB;
  assign w_sum       = regA + regB;
  assign w_diff      = regA - regB;

  // Single-cycle ALU result and signed overflow for ADD/SUB
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_control)
      OP_AND:  w_alu_res = regA & regB;
      OP_OR:   w_alu_res = regA | regB;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (regA[WIDTH-1] == regB[WIDTH-1]) && (w_sum[WIDTH-1] != regA[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (regA[WIDTH-1] != regB[WIDTH-1]) && (w_diff[WIDTH-1] != regA[WIDTH-1]);
      end
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(regA) < $signed(regB))};
      OP_NOR:  w_alu_res = ~(regA | regB);
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  // Iteration step: shift-add multiply and restoring divide, plus sign fix-up
  always_comb begin
    w_madd     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
    w_shift    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_m};
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = r_neg_res ? -w_prod : w_prod;
    w_quo_fix  = r_neg_res ? -r_acc_lo : r_acc_lo;
    w_rem_fix  = r_neg_a ? -r_acc_hi : r_acc_hi;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_is_md) w_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_ITER) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: ALU writeback, operand latch, iterations, HI/LO fix-up
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_m        <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_dvd      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_a    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_md) begin
              r_ovf     <= 1'b0;
              r_is_div  <= w_op_div;
              r_m       <= w_op_div ? w_abs_b : w_abs_a;
              r_acc_lo  <= w_op_div ? w_abs_a : w_abs_b;
              r_acc_hi  <= '0;
              r_dvd     <= regA;
              r_b_zero  <= (regB == '0);
              r_neg_res <= w_signed_md && (regA[WIDTH-1] ^ regB[WIDTH-1]);
              r_neg_a   <= w_signed_md && regA[WIDTH-1];
              r_cnt     <= '0;
            end else begin
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
              r_ovf    <= w_alu_ovf;
              r_done   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            if (!w_trial[WIDTH]) begin
              r_acc_hi <= w_trial[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_acc_hi <= w_shift[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc_hi <= w_madd[WIDTH:1];
            r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_div_zero <= r_b_zero;
            if (r_b_zero) begin
              r_lo <= '1;
              r_hi <= r_dvd;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_zero    = r_div_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed cases, randomized ops with corner operands,
// busy-time start pokes, and a reset abort during a divide.
module tb_alu_mdu;
  localparam int W     = 32;
  localparam int PKT_W = 3*W + 3;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] regA;
  logic [W-1:0] regB;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  always #5 clock = ~clock;

  alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_control(alu_control),
    .regA(regA), .regB(regB), .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [PKT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference architectural state
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_zero = 1'b1;
  logic         m_ovf = 1'b0;
  logic         m_dz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on 64-bit integers
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s, q, r;
    logic [63:0] p;
    logic [W-1:0] res;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    ovf = 1'b0;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: begin
        s = sa + sb; res = W'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb; res = W'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: res = (sa < sb) ? W'(1) : W'(0);
      4'b1100: res = ~(a | b);
      4'b1101: res = m_hi;
      4'b1110: res = m_lo;
      4'b1000: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      4'b1001: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      4'b1010, 4'b1011: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; m_dz = 1'b1;
        end else begin
          if (op[0]) begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end else begin
            q = sa / sb;
            r = sa % sb;
          end
          m_lo = W'(q); m_hi = W'(r); m_dz = 1'b0;
        end
      end
      default: res = '0;
    endcase
    if (op[3:2] == 2'b10) begin
      m_ovf = 1'b0;
    end else begin
      m_result = res;
      m_zero   = (res == '0);
      m_ovf    = ovf;
    end
    exp_q.push_back({m_result, m_zero, m_ovf, m_hi, m_lo, m_dz});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [PKT_W-1:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",   {32'd0, result},   {32'd0, e[PKT_W-1 -: W]});
        check("zero",     {63'd0, zero},     {63'd0, e[2*W+2]});
        check("overflow", {63'd0, overflow}, {63'd0, e[2*W+1]});
        check("hi",       {32'd0, hi},       {32'd0, e[2*W -: W]});
        check("lo",       {32'd0, lo},       {32'd0, e[W -: W]});
        check("div_zero", {63'd0, div_zero}, {63'd0, e[0]});
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke = 1'b0);
    int lat;
    @(negedge clock);
    start = 1'b1; alu_control = op; regA = a; regB = b;
    model_op(op, a, b);
    @(posedge clock); #1;
    start = 1'b0; alu_control = 4'($urandom); regA = $urandom; regB = $urandom;
    if (op[3:2] == 2'b10) begin
      check("md_busy_rise", {63'd0, busy}, 64'd1);
      check("md_no_early_done", {63'd0, done}, 64'd0);
      lat = 0;
      while (!done && lat < 100) begin
        if (poke && lat >= 3 && lat <= 6) begin
          start = 1'b1; alu_control = 4'b0010; regA = $urandom; regB = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clock); #1;
        lat++;
      end
      start = 1'b0;
      check("md_latency", 64'(lat), 64'(W + 1));
      check("md_busy_fall", {63'd0, busy}, 64'd0);
    end else begin
      check("sc_done", {63'd0, done}, 64'd1);
      check("sc_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_abort();
    @(negedge clock);
    start = 1'b1; alu_control = 4'b1010; regA = 32'd100; regB = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; start = 1'b1; alu_control = 4'b0010; regA = 32'd5; regB = 32'd6;
    @(posedge clock); #1;
    check("abort_busy",   {63'd0, busy},  64'd0);
    check("abort_done",   {63'd0, done},  64'd0);
    check("abort_hi",     {32'd0, hi},    64'd0);
    check("abort_lo",     {32'd0, lo},    64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_zero",   {63'd0, zero},  64'd1);
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    m_result = '0; m_hi = '0; m_lo = '0; m_zero = 1'b1; m_ovf = 1'b0; m_dz = 1'b0;
    repeat (40) @(posedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] ops [14];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101,
            4'b1110, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0011, 4'b1111};
    reset = 1'b1; start = 1'b0; alu_control = '0; regA = '0; regB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result",   {32'd0, result}, 64'd0);
    check("rst_zero",     {63'd0, zero},   64'd1);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_busy",     {63'd0, busy},   64'd0);
    check("rst_done",     {63'd0, done},   64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_hi",       {32'd0, hi},     64'd0);
    check("rst_lo",       {32'd0, lo},     64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases
    do_op(4'b0001, 32'd7, 32'd8);
    do_op(4'b0010, 32'd3, 32'd4);
    do_op(4'b0110, 32'd4, 32'd3);
    do_op(4'b0110, 32'd4, 32'd4);
    do_op(4'b0010, 32'h7FFF_FFFF, 32'd1);
    do_op(4'b0110, 32'h8000_0000, 32'd1);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd2);
    do_op(4'b0111, 32'd2, 32'hFFFF_FFFF);
    do_op(4'b1000, 32'hFFFF_FFFD, 32'd5, 1'b1);
    check("mult_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo_const", {32'd0, lo}, 64'hFFFF_FFF1);
    do_op(4'b1110, 32'd0, 32'd0);
    do_op(4'b1001, 32'hFFFF_FFFF, 32'd2);
    do_op(4'b1010, 32'hFFFF_FFF9, 32'd2);
    do_op(4'b1011, 32'd7, 32'd0);
    check("divz_flag_const", {63'd0, div_zero}, 64'd1);
    do_op(4'b0010, 32'd1, 32'd1);
    do_op(4'b1001, 32'd6, 32'd7);
    do_op(4'b1011, 32'd9, 32'd3);
    check("divz_clear_const", {63'd0, div_zero}, 64'd0);
    do_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(4'b1010, 32'hFFFF_FFF0, 32'd0);
    do_op(4'b1101, 32'd0, 32'd0);
    do_op(4'b0011, 32'd5, 32'd9);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      do_op(ops[$urandom_range(0, 13)], pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
    end

    // Reset abort mid-divide, then a clean divide
    repeat (2) @(posedge clock);
    reset_abort();
    do_op(4'b1011, 32'd100, 32'd7);
    check("divu_after_abort_lo", {32'd0, lo}, 64'd14);
    check("divu_after_abort_hi", {32'd0, hi}, 64'd2);

    repeat (5) @(posedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
